// File: rtl/fabric_loopback_pkg.sv
// fabric_loopback_pkg: shared types, wire-group geometry, LFSR constants and
// the north-edge reflection model used by the south-edge loopback tester.
package fabric_loopback_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    localparam logic MODE_WALK = 1'b0;
    localparam logic MODE_PRBS = 1'b1;

    // tx/rx packing: {N4, N2b, N2, N1} and {S4, S2END, S2MID, S1}
    localparam int N1_W    = 4;
    localparam int N2_W    = 8;
    localparam int N2B_W   = 8;
    localparam int N4_W    = 16;
    localparam int N1_OFF  = 0;
    localparam int N2_OFF  = N1_OFF + N1_W;
    localparam int N2B_OFF = N2_OFF + N2_W;
    localparam int N4_OFF  = N2B_OFF + N2B_W;
    localparam int VEC_W   = N4_OFF + N4_W;

    localparam logic [VEC_W-1:0] LFSR_SEED = 36'h1;
    localparam int TAP_A = 35;
    localparam int TAP_B = 24;

    // The north tile returns every group with its bits reversed in place.
    function automatic logic [VEC_W-1:0] reflect(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int j = 0; j < N1_W; j++)  r[N1_OFF + j]  = v[N1_OFF + N1_W - 1 - j];
        for (int j = 0; j < N2_W; j++)  r[N2_OFF + j]  = v[N2_OFF + N2_W - 1 - j];
        for (int j = 0; j < N2B_W; j++) r[N2B_OFF + j] = v[N2B_OFF + N2B_W - 1 - j];
        for (int j = 0; j < N4_W; j++)  r[N4_OFF + j]  = v[N4_OFF + N4_W - 1 - j];
        return r;
    endfunction

endpackage

// File: rtl/loopback_pattern_gen.sv
// loopback_pattern_gen: walking-one / PRBS vector source.
//   clk, rst_n : clock, async active-low reset (clears the pattern state)
//   load       : present the seed and restart the sequence
//   advance    : present the next vector of the sequence and step
//   mode       : 0 = walking-one, 1 = PRBS
//   vector     : vector to launch on this edge (valid when load or advance)
module loopback_pattern_gen
    import fabric_loopback_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic             mode,
    output logic [VEC_W-1:0] vector
);

    logic [VEC_W-1:0] vec_q;

    // Both patterns are left shifts from the same seed; only the fill bit
    // differs (rotate for walking-one, tap XOR for the LFSR).
    always_comb
        vector = load ? LFSR_SEED
                      : {vec_q[VEC_W-2:0], (mode == MODE_PRBS) ? vec_q[TAP_A] ^ vec_q[TAP_B]
                                                               : vec_q[VEC_W-1]};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            vec_q <= '0;
        else if (load || advance)
            vec_q <= vector;

endmodule

// File: rtl/s_term_loopback_tester.sv
// s_term_loopback_tester: drives test vectors north and checks their reflection.
//   UserCLK, rst_n           : clock, async active-low reset
//   start, mode              : begin a run (IDLE/DONE only), pattern select
//   N1BEG/N2BEG/N2BEGb/N4BEG : northbound vector (registered)
//   S1END/S2MID/S2END/S4END  : returned, group-reversed vector
//   busy, done, pass         : run status (registered)
//   err_count, first_err_idx : saturating mismatch count, first failing index
module s_term_loopback_tester
    import fabric_loopback_pkg::*;
#(
    parameter int NUM_VEC  = 256,
    parameter int LOOP_LAT = 1,
    parameter int ERR_W    = 8,
    parameter int IDX_W    = 16
) (
    input  logic             UserCLK,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    output logic [3:0]       N1BEG,
    output logic [7:0]       N2BEG,
    output logic [7:0]       N2BEGb,
    output logic [15:0]      N4BEG,
    input  logic [3:0]       S1END,
    input  logic [7:0]       S2MID,
    input  logic [7:0]       S2END,
    input  logic [15:0]      S4END,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam int DW = $clog2(LOOP_LAT + 1);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [VEC_W-1:0] exp;
    } entry_t;

    state_t           state;
    logic             mode_q;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    dcnt;
    logic [VEC_W-1:0] tx;
    logic [VEC_W-1:0] rx;
    logic [VEC_W-1:0] vector;
    entry_t           pipe [LOOP_LAT];
    entry_t           tail;
    logic             accept;
    logic             last;
    logic             launch;
    logic             mism;

    assign rx = {S4END, S2END, S2MID, S1END};
    assign {N4BEG, N2BEGb, N2BEG, N1BEG} = tx;

    // idx is the index of the vector launched on the current DRIVE edge;
    // reaching NUM_VEC means all vectors are out.
    always_comb begin
        accept = start && (state == IDLE || state == DONE);
        last   = idx == IDX_W'(NUM_VEC);
        launch = accept || (state == DRIVE && !last);
        tail   = pipe[LOOP_LAT-1];
        mism   = tail.valid && rx != tail.exp;
    end

    loopback_pattern_gen u_gen (
        .clk    (UserCLK),
        .rst_n  (rst_n),
        .load   (accept),
        .advance(state == DRIVE && !last),
        .mode   (mode_q),
        .vector (vector)
    );

    always_ff @(posedge UserCLK or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= MODE_WALK;
            idx           <= '0;
            dcnt          <= '0;
            tx            <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            for (int i = 0; i < LOOP_LAT; i++) pipe[i] <= '0;
        end else begin
            // Expected value travels alongside the vector; drain slots are invalid.
            pipe[0] <= launch ? entry_t'{1'b1, accept ? '0 : idx, reflect(vector)} : '0;
            for (int i = 1; i < LOOP_LAT; i++) pipe[i] <= pipe[i-1];
            if (accept) begin
                err_count     <= '0;
                first_err_idx <= '0;
            end else if (mism) begin
                if (~&err_count) err_count <= err_count + ERR_W'(1);
                if (err_count == '0) first_err_idx <= tail.idx;
            end
            case (state)
                IDLE, DONE:
                    if (start) begin
                        state  <= DRIVE;
                        mode_q <= mode;
                        idx    <= IDX_W'(1);
                        tx     <= vector;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        pass   <= 1'b0;
                    end
                DRIVE:
                    if (last) begin
                        state <= DRAIN;
                        tx    <= '0;
                        dcnt  <= '0;
                    end else begin
                        tx  <= vector;
                        idx <= idx + IDX_W'(1);
                    end
                DRAIN:
                    if (dcnt == DW'(LOOP_LAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_count == '0;
                    end else
                        dcnt <= dcnt + DW'(1);
                default: state <= IDLE;
            endcase
        end

endmodule
